if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and talks to a variable-latency instruction memory through a req/gnt/rvalid handshake.
- Feeds instrd/pcd to the decode stage.
- Consumes the decode stage's pcchanged/pcbranchd redirect, with one branch delay slot.

Parameters:
RESET_PC, 32'h00003000, PC value loaded on reset.
NOP_INSTR, 32'h00000000, instruction word inserted as a bubble.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stalld  input  1  hazard unit stall; IF/ID holds its contents while 1.
pcchanged  input  1  decode-stage redirect taken (branch/jump in ID).
pcbranchd  input  32  redirect target from decode stage.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address, equals pcf.
imem_gnt  input  1  request accepted this cycle.
imem_rvalid  input  1  response data valid.
imem_rdata  input  32  fetched instruction.
instrd  output  32  IF/ID instruction.
pcd  output  32  IF/ID instruction address.
pcplus8d  output  32  pcd+8, for link writes.
validd  output  1  IF/ID holds a real instruction.
adeld  output  1  IF/ID slot carries a fetch address error (see Optional Feature).

Behaviour:
- Reset (reset=0, async):
  - pcf=RESET_PC, state=REQ.
  - instrd=NOP_INSTR, pcd=RESET_PC, validd=0, adeld=0.
  - redir_pend=0, redir_tgt=0, hold buffer cleared.
  - No outstanding memory transaction survives reset; the memory shares the reset.
- pcf is always the address of the instruction currently being fetched or held.
- ID consumes its slot when validd=1 and stalld=0. This is the "consume" event below.
- Redirect capture:
  - Condition: consume and pcchanged=1.
  - Result: the next delivered instruction is the delay slot; the fetch after it uses the target.
  - If the delay slot is delivered in the same cycle as the capture, next pcf=pcbranchd directly.
  - Otherwise redir_pend<=1 and redir_tgt<=pcbranchd.
- Next PC on delivery:
  - If a same-cycle capture occurs, use pcbranchd.
  - Else if redir_pend, use redir_tgt and clear redir_pend.
  - Else use pcf+4, with 32-bit wrap-around.
- FSM:
  - REQ: imem_req=1, imem_addr=pcf. On imem_gnt go to WAIT. Otherwise stay, with the address held stable.
  - WAIT: imem_req=0.
    - On imem_rvalid with stalld=0: deliver, i.e. instrd<=imem_rdata, pcd<=pcf, validd<=1. Then pcf<=next PC and go to REQ.
    - On imem_rvalid with stalld=1: latch imem_rdata into the hold buffer and go to HOLD.
  - HOLD: imem_req=0. When stalld=0, deliver the hold buffer, set pcf<=next PC, and go to REQ.
- IF/ID update when nothing is delivered:
  - stalld=1: all IF/ID outputs hold.
  - stalld=0: bubble, i.e. instrd<=NOP_INSTR and validd<=0. pcd holds.
- Only one outstanding transaction. imem_rvalid arrives at least 1 cycle after imem_gnt. imem_rvalid is ignored outside WAIT.
- pcplus8d is combinational, pcd+32'd8.
- Best-case throughput: 1 instruction per 2 cycles with a 1-cycle memory; the REQ→WAIT→REQ loop sets this.

Optional Feature:
- Macro IF_ALIGN_CHK_EN.
- Defined:
  - In REQ with pcf[1:0]!=0, no request is issued.
  - The slot is delivered directly, using the normal stall rules: instrd=NOP_INSTR, pcd=pcf, validd=1, adeld=1.
  - The FSM then enters HALT: no further requests, IF/ID only bubbles, until reset.
  - adeld clears when the slot is consumed.
- Not defined:
  - imem_addr={pcf[31:2],2'b00}.
  - adeld is tied 0.
  - HALT state is absent.

Test Plan:
- Reset release, 1-cycle memory returning 0x24080001, 0x24090002, stalld=0:
  - imem_addr sequence 0x3000, 0x3004.
  - pcd/instrd show 0x3000/0x24080001 then 0x3004/0x24090002.
  - pcplus8d=0x3008 for the first instruction.
- Branch at 0x3000, pcchanged=1 with pcbranchd=0x3100 while 0x3004 (delay slot) is delivered the same cycle:
  - Next imem_addr=0x3100.
  - 0x3004 appears in IF/ID.
- Same branch, memory latency 3, ID consumes the branch before the delay slot returns:
  - validd=0 bubble first, then 0x3004 is delivered.
  - Next imem_addr=0x3100 (redir_pend path).
- stalld=1 held 4 cycles while a response arrives:
  - IF/ID is frozen, FSM in HOLD, imem_req=0.
  - On release the buffered word is delivered and pcf advances by 4.
- Assert reset for 1 cycle while in WAIT at pcf=0x3010:
  - All outputs return to reset values immediately (asynchronous).
  - First request after release is 0x3000.
- With IF_ALIGN_CHK_EN, redirect to pcbranchd=0x3102:
  - No request is issued to 0x3102.
  - Slot is delivered with pcd=0x3102, adeld=1, validd=1, instrd=0.
  - imem_req stays 0 thereafter.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Owns the fetch PC (pcf) and fetches one instruction at a time through a
// req/gnt/rvalid instruction-memory handshake. The result is presented to
// decode in the IF/ID register. A decode-stage redirect (pcchanged/pcbranchd)
// takes effect after one branch delay slot.
//
// Optional feature: define IF_ALIGN_CHK_EN to trap misaligned fetch addresses.
// The trap delivers an adeld-marked NOP slot and then halts fetch until reset.
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset
//   stalld       hazard stall; IF/ID holds while 1
//   pcchanged    decode-stage redirect taken
//   pcbranchd    redirect target
//   imem_req     fetch request
//   imem_addr    fetch address
//   imem_gnt     request accepted
//   imem_rvalid  response valid
//   imem_rdata   fetched instruction
//   instrd       IF/ID instruction
//   pcd          IF/ID instruction address
//   pcplus8d     pcd + 8, for link writes
//   validd       IF/ID holds a real instruction
//   adeld        IF/ID slot carries a fetch address error
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stalld,
  input  logic        pcchanged,
  input  logic [31:0] pcbranchd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrd,
  output logic [31:0] pcd,
  output logic [31:0] pcplus8d,
  output logic        validd,
  output logic        adeld
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef IF_ALIGN_CHK_EN
    , S_HALT
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] pcf;
  logic [31:0] redir_tgt;
  logic        redir_pend;
  logic [31:0] hold_buf;

  logic        consume;
  logic        capture;
  logic [31:0] next_pc;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic        pc_adv;
  logic        latch_hold;

  // ID takes its slot this cycle; a redirect is only meaningful on that event.
  assign consume = validd & ~stalld;
  assign capture = consume & pcchanged;

  // A same-cycle capture wins over a pending one: the delivery in this cycle
  // is itself the delay slot, so the following fetch goes to the new target.
  assign next_pc = capture    ? pcbranchd :
                   redir_pend ? redir_tgt :
                                pcf + 32'd4;

  assign pcplus8d = pcd + 32'd8;

`ifdef IF_ALIGN_CHK_EN
  logic misaligned;
  logic deliver_adel;
  assign misaligned = (pcf[1:0] != 2'b00);
  assign imem_addr  = pcf;
`else
  assign imem_addr  = {pcf[31:2], 2'b00};
`endif

  always_comb begin
    state_n       = state;
    imem_req      = 1'b0;
    deliver       = 1'b0;
    deliver_instr = NOP_INSTR;
    pc_adv        = 1'b0;
    latch_hold    = 1'b0;
`ifdef IF_ALIGN_CHK_EN
    deliver_adel  = 1'b0;
`endif
    case (state)
      S_REQ: begin
`ifdef IF_ALIGN_CHK_EN
        // A misaligned PC never reaches memory; the error slot stands in for
        // the instruction and obeys the same stall rules as a real delivery.
        if (misaligned) begin
          if (!stalld) begin
            deliver      = 1'b1;
            deliver_adel = 1'b1;
            state_n      = S_HALT;
          end
        end else
`endif
        begin
          imem_req = 1'b1;
          if (imem_gnt) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!stalld) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pc_adv        = 1'b1;
            state_n       = S_REQ;
          end else begin
            // Memory cannot be back-pressured, so park the word until ID frees up.
            latch_hold = 1'b1;
            state_n    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stalld) begin
          deliver       = 1'b1;
          deliver_instr = hold_buf;
          pc_adv        = 1'b1;
          state_n       = S_REQ;
        end
      end
`ifdef IF_ALIGN_CHK_EN
      S_HALT: begin
        state_n = S_HALT;
      end
`endif
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_REQ;
      pcf        <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'd0;
      hold_buf   <= 32'd0;
    end else begin
      state <= state_n;
      if (pc_adv) pcf <= next_pc;
      if (latch_hold) hold_buf <= imem_rdata;
      if (pc_adv) begin
        redir_pend <= 1'b0;
      end else if (capture) begin
        // Delay slot still in flight: remember where to go after it lands.
        redir_pend <= 1'b1;
        redir_tgt  <= pcbranchd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrd <= NOP_INSTR;
      pcd    <= RESET_PC;
      validd <= 1'b0;
    end else if (deliver) begin
      instrd <= deliver_instr;
      pcd    <= pcf;
      validd <= 1'b1;
    end else if (!stalld) begin
      // Nothing new arrived and ID moved on: insert a bubble, pcd keeps its value.
      instrd <= NOP_INSTR;
      validd <= 1'b0;
    end
  end

`ifdef IF_ALIGN_CHK_EN
  logic adel_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adel_q <= 1'b0;
    end else if (deliver) begin
      adel_q <= deliver_adel;
    end else if (!stalld) begin
      adel_q <= 1'b0;
    end
  end
  assign adeld = adel_q;
`else
  assign adeld = 1'b0;
`endif

endmodule
